// File: rtl/m_msg_framer.sv
// rtl/m_msg_framer.sv - header+payload frame sequencer over a byte req/ack handshake
// Optional trailing checksum transfer and check: define M_MSG_CHECKSUM_EN.
module m_msg_framer #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 6,
    parameter int MSG_DEPTH = 64,
    parameter int LEN_W     = 7
) (
    input  logic              I_CLK,
    input  logic              I_RESETN,
    input  logic              start,
    input  logic [LEN_W-1:0]  msg_len,
    output logic [ADDR_W-1:0] tx_raddr,
    input  logic [DATA_W-1:0] tx_rdata,
    output logic              xfer_req,
    output logic [DATA_W-1:0] xfer_data,
    input  logic              xfer_ack,
    input  logic [DATA_W-1:0] xfer_rdata,
    output logic              rx_we,
    output logic [ADDR_W-1:0] rx_waddr,
    output logic [DATA_W-1:0] rx_wdata,
    output logic [LEN_W-1:0]  rx_len,
    output logic              busy,
    output logic              done,
    output logic              chk_err
);

`ifdef M_MSG_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_FETCH, S_PAY, S_CSUM, S_FIN} state_t;
    localparam state_t S_TAIL = S_CSUM;
`else
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_FETCH, S_PAY, S_FIN} state_t;
    localparam state_t S_TAIL = S_FIN;
`endif

    localparam logic [LEN_W-1:0]  DEPTH_LEN  = LEN_W'(MSG_DEPTH);
    localparam logic [DATA_W-1:0] DEPTH_BYTE = DATA_W'(MSG_DEPTH);

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] tx_raddr_q, tx_raddr_d;
    logic              xfer_req_q, xfer_req_d;
    logic [DATA_W-1:0] xfer_data_q, xfer_data_d;
    logic              rx_we_q, rx_we_d;
    logic [ADDR_W-1:0] rx_waddr_q, rx_waddr_d;
    logic [DATA_W-1:0] rx_wdata_q, rx_wdata_d;
    logic [LEN_W-1:0]  rx_len_q, rx_len_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              last_byte;
`ifdef M_MSG_CHECKSUM_EN
    logic [DATA_W-1:0] tx_csum_q, tx_csum_d;
    logic [DATA_W-1:0] rx_csum_q, rx_csum_d;
    logic              chk_err_q, chk_err_d;
`endif

    assign last_byte = ((LEN_W'(idx_q) + LEN_W'(1)) == len_q);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        xfer_req_d  = xfer_req_q;
        xfer_data_d = xfer_data_q;
        rx_we_d     = 1'b0;
        rx_waddr_d  = rx_waddr_q;
        rx_wdata_d  = rx_wdata_q;
        rx_len_d    = rx_len_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef M_MSG_CHECKSUM_EN
        tx_csum_d   = tx_csum_q;
        rx_csum_d   = rx_csum_q;
        chk_err_d   = chk_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                // The done cycle is already IDLE, so a start there must be dropped explicitly.
                if (start && !done_q) begin
                    len_d       = (msg_len > DEPTH_LEN) ? DEPTH_LEN : msg_len;
                    idx_d       = '0;
                    busy_d      = 1'b1;
                    xfer_req_d  = 1'b1;
                    xfer_data_d = DATA_W'(len_d);
                    state_d     = S_HDR;
`ifdef M_MSG_CHECKSUM_EN
                    tx_csum_d   = DATA_W'(len_d);
                    chk_err_d   = 1'b0;
`endif
                end
            end
            S_HDR: begin
                if (xfer_ack) begin
                    xfer_req_d = 1'b0;
                    rx_len_d   = (xfer_rdata > DEPTH_BYTE) ? DEPTH_LEN : LEN_W'(xfer_rdata);
                    state_d    = (len_q == '0) ? S_TAIL : S_FETCH;
`ifdef M_MSG_CHECKSUM_EN
                    rx_csum_d  = xfer_rdata;
`endif
                end
            end
            S_FETCH: begin
                state_d = S_PAY;
            end
            S_PAY: begin
                // First PAY cycle captures the buffer word; the request rises after it.
                if (!xfer_req_q) begin
                    xfer_data_d = tx_rdata;
                    xfer_req_d  = 1'b1;
`ifdef M_MSG_CHECKSUM_EN
                    tx_csum_d   = tx_csum_q ^ tx_rdata;
`endif
                end else if (xfer_ack) begin
                    xfer_req_d = 1'b0;
                    rx_we_d    = 1'b1;
                    rx_waddr_d = idx_q;
                    rx_wdata_d = xfer_rdata;
`ifdef M_MSG_CHECKSUM_EN
                    rx_csum_d  = rx_csum_q ^ xfer_rdata;
`endif
                    if (last_byte) begin
                        state_d = S_TAIL;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
`ifdef M_MSG_CHECKSUM_EN
            S_CSUM: begin
                if (!xfer_req_q) begin
                    xfer_data_d = tx_csum_q;
                    xfer_req_d  = 1'b1;
                end else if (xfer_ack) begin
                    xfer_req_d = 1'b0;
                    chk_err_d  = ((rx_csum_q ^ xfer_rdata) != '0);
                    state_d    = S_FIN;
                end
            end
`endif
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        tx_raddr_d = idx_d;
    end

    always_ff @(posedge I_CLK or negedge I_RESETN) begin
        if (!I_RESETN) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            tx_raddr_q  <= '0;
            xfer_req_q  <= 1'b0;
            xfer_data_q <= '0;
            rx_we_q     <= 1'b0;
            rx_waddr_q  <= '0;
            rx_wdata_q  <= '0;
            rx_len_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef M_MSG_CHECKSUM_EN
            tx_csum_q   <= '0;
            rx_csum_q   <= '0;
            chk_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            tx_raddr_q  <= tx_raddr_d;
            xfer_req_q  <= xfer_req_d;
            xfer_data_q <= xfer_data_d;
            rx_we_q     <= rx_we_d;
            rx_waddr_q  <= rx_waddr_d;
            rx_wdata_q  <= rx_wdata_d;
            rx_len_q    <= rx_len_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef M_MSG_CHECKSUM_EN
            tx_csum_q   <= tx_csum_d;
            rx_csum_q   <= rx_csum_d;
            chk_err_q   <= chk_err_d;
`endif
        end
    end

    assign tx_raddr  = tx_raddr_q;
    assign xfer_req  = xfer_req_q;
    assign xfer_data = xfer_data_q;
    assign rx_we     = rx_we_q;
    assign rx_waddr  = rx_waddr_q;
    assign rx_wdata  = rx_wdata_q;
    assign rx_len    = rx_len_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef M_MSG_CHECKSUM_EN
    assign chk_err   = chk_err_q;
`else
    assign chk_err   = 1'b0;
`endif

endmodule

// File: tb/tb_m_msg_framer.sv
// tb/tb_m_msg_framer.sv - scoreboard bench for m_msg_framer
module tb_m_msg_framer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;
    localparam int MSG_DEPTH = 64;
    localparam int LEN_W = 7;
`ifdef M_MSG_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic              I_CLK = 1'b0;
    logic              I_RESETN = 1'b0;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  msg_len = '0;
    logic [ADDR_W-1:0] tx_raddr;
    logic [DATA_W-1:0] tx_rdata;
    logic              xfer_req;
    logic [DATA_W-1:0] xfer_data;
    logic              xfer_ack;
    logic [DATA_W-1:0] xfer_rdata;
    logic              rx_we;
    logic [ADDR_W-1:0] rx_waddr;
    logic [DATA_W-1:0] rx_wdata;
    logic [LEN_W-1:0]  rx_len;
    logic              busy;
    logic              done;
    logic              chk_err;

    m_msg_framer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MSG_DEPTH(MSG_DEPTH), .LEN_W(LEN_W)) dut (
        .I_CLK(I_CLK), .I_RESETN(I_RESETN), .start(start), .msg_len(msg_len),
        .tx_raddr(tx_raddr), .tx_rdata(tx_rdata),
        .xfer_req(xfer_req), .xfer_data(xfer_data), .xfer_ack(xfer_ack), .xfer_rdata(xfer_rdata),
        .rx_we(rx_we), .rx_waddr(rx_waddr), .rx_wdata(rx_wdata), .rx_len(rx_len),
        .busy(busy), .done(done), .chk_err(chk_err)
    );

    always #5 I_CLK = ~I_CLK;

    logic [7:0]  mem [64];
    logic [7:0]  spay [64];
    logic [7:0]  exp_tx_q [$];
    logic [7:0]  slave_q [$];
    logic [13:0] exp_rx_q [$];
    int checks = 0;
    int passes = 0;
    int ack_cnt = 0;
    int done_cnt = 0;

    always @(posedge I_CLK) tx_rdata <= mem[tx_raddr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    // Slave: acks each request three cycles after it is seen, returning queued bytes.
    initial begin
        int wcnt;
        wcnt = 0;
        xfer_ack = 1'b0;
        xfer_rdata = '0;
        forever begin
            @(posedge I_CLK); #1;
            if (!I_RESETN) begin
                xfer_ack = 1'b0;
                wcnt = 0;
            end else if (xfer_ack) begin
                xfer_ack = 1'b0;
            end else if (xfer_req) begin
                wcnt++;
                if (wcnt == 3) begin
                    wcnt = 0;
                    xfer_ack = 1'b1;
                    xfer_rdata = (slave_q.size() != 0) ? slave_q.pop_front() : 8'h00;
                end
            end
        end
    end

    // Monitor: pops expected transfers/writes as the DUT presents them.
    initial begin
        logic       gap;
        logic       req_prev;
        logic [7:0] data_prev;
        logic [13:0] e;
        gap = 1'b0;
        req_prev = 1'b0;
        data_prev = '0;
        forever begin
            @(negedge I_CLK);
            if (!I_RESETN) begin
                gap = 1'b0;
                req_prev = 1'b0;
            end else begin
                if (gap) begin
                    chk("req_gap_after_ack", xfer_req, 0);
                    gap = 1'b0;
                end
                if (xfer_req && req_prev) chk("xfer_data_stable", xfer_data, data_prev);
                if (xfer_req && xfer_ack) begin
                    ack_cnt++;
                    chk("tx_expected", 32'(exp_tx_q.size() != 0), 1);
                    if (exp_tx_q.size() != 0) chk("xfer_data", xfer_data, exp_tx_q.pop_front());
                    gap = 1'b1;
                end
                if (rx_we) begin
                    chk("rx_we_expected", 32'(exp_rx_q.size() != 0), 1);
                    if (exp_rx_q.size() != 0) begin
                        e = exp_rx_q.pop_front();
                        chk("rx_waddr", rx_waddr, e[13:8]);
                        chk("rx_wdata", rx_wdata, e[7:0]);
                    end
                end
                if (done) done_cnt++;
                req_prev = xfer_req;
                data_prev = xfer_data;
            end
        end
    end

    task automatic load_frame(input int len_eff, input logic [7:0] s_hdr, input logic bad);
        logic [7:0] tc, rc;
        tc = 8'(len_eff);
        rc = s_hdr;
        exp_tx_q.push_back(tc);
        slave_q.push_back(s_hdr);
        for (int k = 0; k < len_eff; k++) begin
            exp_tx_q.push_back(mem[k]);
            tc ^= mem[k];
            slave_q.push_back(spay[k]);
            rc ^= spay[k];
            exp_rx_q.push_back({6'(k), spay[k]});
        end
        if (CS == 1) begin
            exp_tx_q.push_back(tc);
            slave_q.push_back(rc ^ {7'd0, bad});
        end
    endtask

    task automatic pulse_start(input logic [LEN_W-1:0] l);
        @(posedge I_CLK); #1;
        msg_len = l;
        start = 1'b1;
        @(posedge I_CLK); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge I_CLK); #1;
            if (done) break;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_xfer_req"}, xfer_req, 0);
        chk({tag, "_xfer_data"}, xfer_data, 0);
        chk({tag, "_tx_raddr"}, tx_raddr, 0);
        chk({tag, "_rx_we"}, rx_we, 0);
        chk({tag, "_rx_waddr"}, rx_waddr, 0);
        chk({tag, "_rx_wdata"}, rx_wdata, 0);
        chk({tag, "_rx_len"}, rx_len, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_chk_err"}, chk_err, 0);
    endtask

    task automatic settle_and_check(input string tag, input int a0, input int d0, input int n_xfer);
        repeat (20) @(posedge I_CLK);
        #1;
        chk({tag, "_xfers"}, ack_cnt - a0, n_xfer);
        chk({tag, "_done_count"}, done_cnt - d0, 1);
        chk({tag, "_busy_idle"}, busy, 0);
        chk({tag, "_tx_q_empty"}, exp_tx_q.size(), 0);
        chk({tag, "_rx_q_empty"}, exp_rx_q.size(), 0);
    endtask

    initial begin
        int a0, d0;
        string s_master, s_slave;
        s_master = "MASTER";
        s_slave = "SLAVE?";
        for (int i = 0; i < 64; i++) begin
            mem[i] = '0;
            spay[i] = '0;
        end

        repeat (3) @(posedge I_CLK);
        #1;
        check_reset_vals("reset");
        I_RESETN = 1'b1;

        // Frame 1: "MASTER" out, header 0x05 + "SLAVE?" back; stray starts mid-frame and in done cycle.
        for (int i = 0; i < 6; i++) begin
            mem[i] = s_master[i];
            spay[i] = s_slave[i];
        end
        load_frame(6, 8'h05, 1'b0);
        a0 = ack_cnt;
        d0 = done_cnt;
        pulse_start(7'd6);
        chk("t1_busy_after_start", busy, 1);
        chk("t1_req_after_start", xfer_req, 1);
        chk("t1_hdr_byte", xfer_data, 8'h06);
        repeat (10) @(posedge I_CLK);
        #1;
        msg_len = 7'd1;
        start = 1'b1;
        @(posedge I_CLK); #1;
        start = 1'b0;
        chk("t1_busy_mid", busy, 1);
        wait_done(400);
        chk("t1_busy_with_done", busy, 0);
        msg_len = 7'd2;
        start = 1'b1;
        @(posedge I_CLK); #1;
        start = 1'b0;
        chk("t1_start_in_done_busy", busy, 0);
        chk("t1_start_in_done_req", xfer_req, 0);
        settle_and_check("t1", a0, d0, 7 + CS);
        chk("t1_rx_len", rx_len, 5);
        chk("t1_chk_err", chk_err, 0);

        // Frame 2: zero-length message.
        load_frame(0, 8'h00, 1'b0);
        a0 = ack_cnt;
        d0 = done_cnt;
        pulse_start(7'd0);
        chk("t2_hdr_byte", xfer_data, 8'h00);
        wait_done(200);
        settle_and_check("t2", a0, d0, 1 + CS);
        chk("t2_rx_len", rx_len, 0);

        // Frame 3: oversize length saturates to 64, slave header 0xFF saturates rx_len.
        for (int i = 0; i < 64; i++) begin
            mem[i] = 8'(i * 3 + 1);
            spay[i] = ~8'(i);
        end
        load_frame(64, 8'hFF, 1'b0);
        a0 = ack_cnt;
        d0 = done_cnt;
        pulse_start(7'd100);
        chk("t3_hdr_byte", xfer_data, 8'h40);
        wait_done(3000);
        settle_and_check("t3", a0, d0, 65 + CS);
        chk("t3_rx_len", rx_len, 64);
        chk("t3_last_waddr", rx_waddr, 63);

        // Frame 4: reset asserted after three completed transfers.
        for (int i = 0; i < 6; i++) begin
            mem[i] = s_master[i];
            spay[i] = s_slave[i];
        end
        load_frame(6, 8'h05, 1'b0);
        a0 = ack_cnt;
        d0 = done_cnt;
        pulse_start(7'd6);
        for (int i = 0; i < 200; i++) begin
            @(posedge I_CLK); #1;
            if (ack_cnt - a0 >= 3) break;
        end
        chk("t4_three_acks", 32'(ack_cnt - a0 >= 3), 1);
        repeat (2) @(posedge I_CLK);
        #2;
        I_RESETN = 1'b0;
        #1;
        check_reset_vals("t4_in_reset");
        exp_tx_q.delete();
        exp_rx_q.delete();
        slave_q.delete();
        repeat (3) @(posedge I_CLK);
        #1;
        I_RESETN = 1'b1;
        repeat (30) @(posedge I_CLK);
        #1;
        chk("t4_no_done", done_cnt - d0, 0);
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_req", xfer_req, 0);
        chk("t4_no_more_xfers", ack_cnt - a0, 3);

`ifdef M_MSG_CHECKSUM_EN
        // Checksum: payload 01,02 -> checksum byte 0x01; then a corrupted slave checksum.
        mem[0] = 8'h01;
        mem[1] = 8'h02;
        spay[0] = 8'hAA;
        spay[1] = 8'h55;
        load_frame(2, 8'h02, 1'b0);
        chk("t5_tx_csum_model", exp_tx_q[3], 8'h01);
        a0 = ack_cnt;
        d0 = done_cnt;
        pulse_start(7'd2);
        wait_done(400);
        chk("t5_chk_ok", chk_err, 0);
        settle_and_check("t5", a0, d0, 4);

        load_frame(2, 8'h02, 1'b1);
        a0 = ack_cnt;
        d0 = done_cnt;
        pulse_start(7'd2);
        wait_done(400);
        chk("t6_chk_err_with_done", chk_err, 1);
        settle_and_check("t6", a0, d0, 4);
        chk("t6_chk_err_held", chk_err, 1);

        load_frame(0, 8'h00, 1'b0);
        a0 = ack_cnt;
        d0 = done_cnt;
        pulse_start(7'd0);
        chk("t7_chk_err_cleared", chk_err, 0);
        wait_done(200);
        settle_and_check("t7", a0, d0, 2);
        chk("t7_chk_ok", chk_err, 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/m_msg_framer.md
# m_msg_framer

Frame sequencer placed directly upstream of the SPI control stage in the master design. On a debounced `start` pulse it reads an outgoing message from the transmit message buffer and issues it byte by byte over a req/ack handshake: first a length header, then the payload. Each byte that returns from the slave is written into the receive message buffer. This keeps the SPI control block a single-byte engine and keeps message indexing out of the top level.

## Interface
Parameters:
- `DATA_W`, 8: byte width.
- `ADDR_W`, 6: message buffer address width.
- `MSG_DEPTH`, 64: maximum payload bytes per frame.
- `LEN_W`, 7: width of length fields; must hold values 0..MSG_DEPTH.

Ports:
- `I_CLK`  in  1  system clock; all logic on the rising edge.
- `I_RESETN`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request to send a frame; ignored while `busy`.
- `msg_len`  in  LEN_W  payload length; sampled on an accepted `start`.
- `tx_raddr`  out  ADDR_W  transmit buffer read address.
- `tx_rdata`  in  DATA_W  transmit buffer data; synchronous read, valid one cycle after `tx_raddr`.
- `xfer_req`  out  1  byte transfer request to the SPI control stage.
- `xfer_data`  out  DATA_W  byte to transmit; stable while `xfer_req`=1.
- `xfer_ack`  in  1  one-cycle pulse: transfer complete, `xfer_rdata` valid.
- `xfer_rdata`  in  DATA_W  byte received from the slave.
- `rx_we`  out  1  receive buffer write strobe.
- `rx_waddr`  out  ADDR_W  receive buffer write address.
- `rx_wdata`  out  DATA_W  receive buffer write data.
- `rx_len`  out  LEN_W  slave's header byte, saturated to MSG_DEPTH.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse at frame end.
- `chk_err`  out  1  checksum mismatch on the last frame.

## Operation
- States:
  - IDLE: waits for `start`.
  - HDR: requests the header byte.
  - FETCH: one cycle to present `tx_raddr`.
  - PAY: requests a payload byte.
  - CSUM: requests the checksum byte; macro-dependent.
  - FIN: pulses `done`, returns to IDLE.
- Accepted `start`: latch `len = min(msg_len, MSG_DEPTH)`, clear the payload index `idx`, set `busy`, go to HDR.
- HDR: `xfer_data = len` zero-extended to DATA_W.
  - On ack: `rx_len = min(xfer_rdata, MSG_DEPTH)`.
  - If `len`=0: go to CSUM when the macro is defined, else FIN.
  - Otherwise go to FETCH.
- FETCH: `tx_raddr = idx`; next cycle go to PAY with `xfer_data = tx_rdata`, registered.
- PAY, on ack:
  - Write `xfer_rdata` to `rx_waddr = idx`.
  - If `idx = len-1`: go to CSUM or FIN.
  - Otherwise `idx+1`, go to FETCH.
- The header's returned byte is never written to the receive buffer. Payload byte k goes to address k, with k < 64, so there is no wrap.
- Slave bytes beyond `len` are never requested. The receive buffer beyond `len` is left untouched.
- `rx_len` is reported only; it does not change the transfer count.

## Timing
- Reset values: `xfer_req`=0, `xfer_data`=0, `tx_raddr`=0, `rx_we`=0, `rx_waddr`=0, `rx_wdata`=0, `rx_len`=0, `busy`=0, `done`=0, `chk_err`=0; state IDLE.
- `start` sampled at edge N: `busy`=1 and `xfer_req`=1 from N+1.
- Handshake:
  - `xfer_req` is held and `xfer_data` is stable until an edge samples `xfer_ack`=1.
  - `xfer_req` is 0 the next cycle.
  - At least one idle cycle separates requests.
  - `xfer_ack` while `xfer_req`=0 is ignored.
- `rx_we` is a one-cycle pulse in the cycle after the ack, with registered address and data.
- After the final ack: `done`=1 for one cycle, next cycle after that; `busy` falls together with `done`.
- Per-byte overhead: header 1 cycle + SPI time; each payload byte 2 cycles + SPI time.
- `start` while busy or in the `done` cycle: dropped, never queued.
- `I_RESETN` low mid-frame: immediate return to reset values. No `done` pulse and no partial write completes.

## Configuration
- `M_MSG_CHECKSUM_EN` defined:
  - After the last payload byte (or after the header when `len`=0), CSUM sends the XOR of the header and all sent payload bytes.
  - The XOR of every received byte, including the slave's checksum, must be 0.
  - Otherwise `chk_err`=1, valid with `done` and held until the next accepted `start`, which clears it.
  - Frame = `len+2` transfers.
- Not defined: no CSUM state, `chk_err` tied 0, frame = `len+1` transfers.

## Test plan
- `msg_len`=6, buffer "MASTER", ack 3 cycles after each req -> `xfer_data` sequence 0x06,'M','A','S','T','E','R'; slave bytes 0x05,"SLAVE?" -> `rx_len`=5, rx addr 0..5 = "SLAVE?"; single `done`.
- `msg_len`=0 -> one header transfer of 0x00, no `rx_we`, `done` after the ack (with the macro: two transfers, checksum 0x00).
- `msg_len`=100 -> header 0x40, 64 payload reads at addresses 0..63, last `rx_waddr`=63; slave header 0xFF -> `rx_len`=64.
- `start` pulsed mid-frame and in the `done` cycle -> ignored, transfer count unchanged; `I_RESETN` low after 3 bytes -> all outputs at reset values, no `done`.
- Macro defined, payload 0x01,0x02, `msg_len`=2 -> checksum byte 0x01; slave returns consistent bytes -> `chk_err`=0; one flipped bit -> `chk_err`=1 until the next `start`.
